// File: rtl/filter_decimator.sv
// Integrate-and-dump decimator (N = 2^k) that feeds a small first-word-fall-through output FIFO.
// A sticky overflow flag records any result that was dropped because the FIFO was full.
module filter_decimator #(
  parameter int DATA_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         Clk_i,
  input  logic                         RstN_i,
  input  logic [DATA_W-1:0]            Data_i,
  input  logic                         DataNd_i,
  input  logic [1:0]                   DecLog2_i,
  input  logic                         Ready_i,
  output logic [DATA_W-1:0]            Data_o,
  output logic                         DataValid_o,
  output logic [$clog2(FIFO_DEPTH):0]  FifoLevel_o,
  output logic                         Overflow_o
);

  localparam int          ACC_W    = DATA_W + 3;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [1:0]               k_q, k_d;
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]        mem_d [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              level_q, level_d;
  logic                     ovf_q, ovf_d;
  logic                     valid_q, valid_d;
  logic [DATA_W-1:0]        data_q, data_d;

  logic [1:0]               k_eff_s;
  logic [2:0]               last_cnt_s;
  logic signed [ACC_W-1:0]  sample_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic [DATA_W-1:0]        result_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     full_s;
  logic                     wr_en_s;

  // Accumulate accepted samples; dump the floored average on the Nth one.
  always_comb begin
    // The exponent is taken live at the first sample of a block, then held.
    k_eff_s  = (cnt_q == 3'd0) ? DecLog2_i : k_q;
    sample_s = {{3{Data_i[DATA_W-1]}}, Data_i};
    sum_s    = acc_q + sample_s;
    result_s = DATA_W'(sum_s >>> k_eff_s);
    case (k_eff_s)
      2'd0:    last_cnt_s = 3'd0;
      2'd1:    last_cnt_s = 3'd1;
      2'd2:    last_cnt_s = 3'd3;
      default: last_cnt_s = 3'd7;
    endcase
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    push_s = 1'b0;
    if (DataNd_i) begin
      k_d = k_eff_s;
      if (cnt_q == last_cnt_s) begin
        acc_d  = '0;
        cnt_d  = 3'd0;
        push_s = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      k_d = k_q;
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops on the same edge.
  always_comb begin
    full_s  = (level_q == LVL_FULL);
    pop_s   = valid_q && Ready_i;
    wr_en_s = push_s && (!full_s || pop_s);
    mem_d   = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = result_s;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d   = ovf_q | (push_s & full_s & ~pop_s);
    valid_d = (level_d != '0);
    data_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // State and registered outputs.
  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      acc_q    <= '0;
      cnt_q    <= 3'd0;
      k_q      <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      mem_q    <= mem_d;
    end
  end

  assign Data_o      = data_q;
  assign DataValid_o = valid_q;
  assign FifoLevel_o = level_q;
  assign Overflow_o  = ovf_q;

endmodule

// File: tb/tb_filter_decimator.sv
// Scoreboard bench for filter_decimator: directed scenarios plus randomized traffic against a
// sample-list / queue reference model; a separate monitor checks every popped word.
module tb_filter_decimator;
  localparam int DW    = 18;
  localparam int DEPTH = 4;

  logic          Clk_i = 1'b0;
  logic          RstN_i;
  logic [DW-1:0] Data_i;
  logic          DataNd_i;
  logic [1:0]    DecLog2_i;
  logic          Ready_i;
  logic [DW-1:0] Data_o;
  logic          DataValid_o;
  logic [2:0]    FifoLevel_o;
  logic          Overflow_o;

  filter_decimator #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .Clk_i(Clk_i), .RstN_i(RstN_i), .Data_i(Data_i), .DataNd_i(DataNd_i),
    .DecLog2_i(DecLog2_i), .Ready_i(Ready_i), .Data_o(Data_o),
    .DataValid_o(DataValid_o), .FifoLevel_o(FifoLevel_o), .Overflow_o(Overflow_o)
  );

  always #5 Clk_i = ~Clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0]        exp_q[$];
  logic signed [DW-1:0] blk[$];
  int                   mk   = 0;
  int                   mocc = 0;
  int                   movf = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; checks status against the model, then advances the model over the next edge.
  task automatic step(input logic nd, input logic [DW-1:0] d, input logic [1:0] k, input logic rdy);
    int sum, n, q;
    logic [DW-1:0] res;
    logic have_res, pop_m;
    @(negedge Clk_i);
    chk("level", int'(FifoLevel_o), mocc);
    chk("valid", int'(DataValid_o), (mocc != 0) ? 1 : 0);
    chk("overflow", int'(Overflow_o), movf);
    DataNd_i = nd; Data_i = d; DecLog2_i = k; Ready_i = rdy;
    have_res = 1'b0;
    res = '0;
    if (nd) begin
      if (blk.size() == 0) mk = int'(k);
      blk.push_back($signed(d));
      n = 1 << mk;
      if (blk.size() == n) begin
        sum = 0;
        foreach (blk[i]) sum += int'(blk[i]);
        q = sum / n;
        if ((sum % n) != 0 && sum < 0) q = q - 1;
        res = q[DW-1:0];
        have_res = 1'b1;
        blk.delete();
      end
    end
    pop_m = (mocc > 0) && rdy;
    if (have_res) begin
      if (mocc < DEPTH || pop_m) begin
        exp_q.push_back(res);
        mocc++;
      end else begin
        movf = 1;
      end
    end
    if (pop_m) mocc--;
  endtask

  // Monitor: every word the DUT hands over must be the next expected one.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge Clk_i);
      #1;
      if (RstN_i && DataValid_o && Ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_unexpected: got %h expected none", Data_o);
        end else begin
          e = exp_q.pop_front();
          if (Data_o !== e) begin
            n_fail++;
            $display("FAIL data: got %h expected %h at %0t", Data_o, e, $time);
          end
        end
      end
    end
  end

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 2'd0, 1'b1);
  endtask

  initial begin
    RstN_i = 1'b0; DataNd_i = 1'b0; Data_i = '0; DecLog2_i = 2'd0; Ready_i = 1'b0;
    #12;
    chk("reset_valid", int'(DataValid_o), 0);
    chk("reset_data", int'(Data_o), 0);
    chk("reset_level", int'(FifoLevel_o), 0);
    chk("reset_ovf", int'(Overflow_o), 0);
    @(negedge Clk_i);
    RstN_i = 1'b1;
    drain(2);

    // Impulse in a block of zeros, k=2
    step(1'b1, 18'h00000, 2'd2, 1'b1);
    step(1'b1, 18'h1FFFF, 2'd2, 1'b1);
    step(1'b1, 18'h00000, 2'd2, 1'b1);
    step(1'b1, 18'h00000, 2'd2, 1'b1);
    drain(3);

    // Negative values and floor rounding, k=2
    for (int i = 0; i < 4; i++) step(1'b1, 18'h3FFFF, 2'd2, 1'b1);
    step(1'b1, 18'h3FFFF, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 18'h00000, 2'd2, 1'b1);
    drain(3);

    // Pass-through ramp, continuous and gapped
    for (int i = 1; i <= 10; i++) step(1'b1, DW'(i), 2'd0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, DW'(i), 2'd0, 1'b1);
      step(1'b0, '0, 2'd0, 1'b1);
    end
    drain(3);

    // Full FIFO with simultaneous push and pop
    for (int i = 11; i <= 14; i++) step(1'b1, DW'(i), 2'd0, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0);
    step(1'b1, DW'(15), 2'd0, 1'b1);
    drain(7);

    // Overflow: five results into a four-deep FIFO
    for (int i = 21; i <= 25; i++) step(1'b1, DW'(i), 2'd0, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0);
    drain(7);

    // Mid-block asynchronous reset, k=3
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i + 100), 2'd3, 1'b1);
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    #2 RstN_i = 1'b0;
    #1;
    chk("areset_valid", int'(DataValid_o), 0);
    chk("areset_data", int'(Data_o), 0);
    chk("areset_level", int'(FifoLevel_o), 0);
    chk("areset_ovf", int'(Overflow_o), 0);
    blk.delete(); exp_q.delete(); mocc = 0; movf = 0;
    @(negedge Clk_i);
    RstN_i = 1'b1;
    drain(2);
    for (int i = 0; i < 8; i++) step(1'b1, 18'h00008, 2'd3, 1'b1);
    drain(3);

    // Randomized traffic: gaps, back-pressure, k changes mid-block
    for (int i = 0; i < 800; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      if ($urandom_range(0, 7) == 0) d = 18'h1FFFF;
      if ($urandom_range(0, 7) == 0) d = 18'h20000;
      step(($urandom_range(0, 3) != 0), d, 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 60 && (exp_q.size() != 0 || mocc != 0); i++) step(1'b0, '0, 2'd0, 1'b1);
    drain(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/filter_decimator.md
FILTER_DECIMATOR -- requirements
Module: filter_decimator

Interface
REQ-001 Parameter DATA_W, default 18, width of the input and output samples (two's complement).
REQ-002 Parameter FIFO_DEPTH, default 4, number of output FIFO entries; SHALL be a power of two.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 Clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RstN_i  input  1  asynchronous active-low reset.
REQ-006 Data_i  input  DATA_W  signed sample from the systolic filter output (its Data_o).
REQ-007 DataNd_i  input  1  Data_i is valid this cycle (driven by the filter's DataValid_o).
REQ-008 DecLog2_i  input  2  decimation exponent k; the decimation factor is N = 2^k (1, 2, 4 or 8).
REQ-009 Ready_i  input  1  downstream accepts the output word this cycle.
REQ-010 Data_o  output  DATA_W  signed decimated average (head of the FIFO).
REQ-011 DataValid_o  output  1  Data_o holds a valid word (FIFO not empty).
REQ-012 FifoLevel_o  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 Overflow_o  output  1  sticky flag: a result was dropped because the FIFO was full.

Function
REQ-014 Integrate-and-dump: the accumulator SHALL be DATA_W+3 bits, signed, and SHALL sum N consecutive samples accepted with DataNd_i=1.
REQ-015 Cycles with DataNd_i=0 SHALL leave the accumulator and the sample counter unchanged.
REQ-016 The sample counter SHALL be 3 bits and SHALL wrap to 0 after the Nth sample.
REQ-017 On the Nth sample edge, the block SHALL form result = (acc + Data_i) >>> k (arithmetic shift, rounding toward -inf), SHALL take the low DATA_W bits, and SHALL clear the accumulator in the same edge.
REQ-018 k SHALL be latched when the counter is 0 and a sample is accepted; changes to DecLog2_i mid-block SHALL take effect only at the next block.
REQ-019 With k=0, every accepted sample SHALL pass through unchanged (N=1).
REQ-020 The result SHALL be pushed into the FIFO on the Nth sample edge; DataValid_o SHALL assert in the cycle after that edge (latency 1 cycle when the FIFO was empty).
REQ-021 The FIFO SHALL be first-word-fall-through; a pop SHALL occur on an edge where DataValid_o=1 and Ready_i=1.
REQ-022 Ready_i while the FIFO is empty SHALL have no effect.
REQ-023 Push while the FIFO is full with no pop: the new result SHALL be dropped, the stored data SHALL be unchanged, and Overflow_o SHALL be set.
REQ-024 Push and pop on the same edge when the FIFO is full SHALL both succeed, with the level unchanged and Overflow_o not set.
REQ-025 Push and pop on the same edge at any other level SHALL leave the level unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; FifoLevel_o SHALL range from 0 to FIFO_DEPTH.
REQ-027 Overflow_o SHALL clear only on reset.

Reset
REQ-028 While RstN_i=0, the accumulator, counter, FIFO pointers and level, and Overflow_o SHALL be 0; DataValid_o SHALL be 0; Data_o SHALL be 0; latched k SHALL be 0.
REQ-029 Reset asserted mid-block SHALL discard the partial sum; the first sample accepted after deassertion SHALL start a new block.
REQ-030 Deassertion SHALL be usable on any edge; no output SHALL change until the first accepted sample.

Verification
REQ-031 k=2, constant DataNd_i=1, Ready_i=1, a single 18'h1FFFF impulse in a block of zeros -> exactly one word 18'h07FFF, one cycle after the 4th sample of that block.
REQ-032 k=2, four samples of 18'h3FFFF -> 18'h3FFFF; k=2, one 18'h3FFFF followed by three zeros -> 18'h3FFFF (floor of -1/4).
REQ-033 k=0, ramp 1..10 with DataNd_i=1 each cycle -> Data_o = 1..10 in order, each one cycle later; DataNd_i gapped every other cycle -> the same sequence, gapped.
REQ-034 Ready_i=0, k=0, 5 samples A..E -> FifoLevel_o=4, Overflow_o=1, FIFO holds A..D; then Ready_i=1 -> A, B, C, D drained and the level returns to 0.
REQ-035 FIFO full, Ready_i=1, and a push on the same edge -> level stays 4, Overflow_o stays 0, and the output order is preserved.
REQ-036 k=3, 5 samples accepted, then RstN_i pulsed low asynchronously mid-cycle -> all outputs 0 immediately; then 8 samples of 18'h00008 -> one word 18'h00008.
